// File: rtl/escaner_teclado_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encodings,
// key-code constants, and the (row, column) to key-code mapping.
package escaner_teclado_pkg;

    localparam logic [1:0] ST_SCAN    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Rows 0..2 of columns 0..2 hold the digits 1..9 in reading order.
    function automatic logic [3:0] codigo_tecla(input logic [1:0] fila, input logic [1:0] col);
        logic [3:0] codigo;
        codigo = 4'd0;
        if (col == 2'd3) begin
            case (fila)
                2'd0:    codigo = KEY_A;
                2'd1:    codigo = KEY_B;
                2'd2:    codigo = KEY_C;
                default: codigo = KEY_D;
            endcase
        end else if (fila == 2'd3) begin
            case (col)
                2'd0:    codigo = KEY_STAR;
                2'd1:    codigo = 4'd0;
                default: codigo = KEY_HASH;
            endcase
        end else begin
            codigo = ({2'b00, fila} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return codigo;
    endfunction

    function automatic logic [3:0] columna_activa(input logic [1:0] col);
        logic [3:0] drive;
        case (col)
            2'd0:    drive = 4'b0111;
            2'd1:    drive = 4'b1011;
            2'd2:    drive = 4'b1101;
            default: drive = 4'b1110;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/escaner_teclado_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to all ones
// so an idle (pulled-up) bus reads as released.
module sincronizador #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] etapa;

    // Metastability-settling stage followed by the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            etapa <= {WIDTH{1'b1}};
            q     <= {WIDTH{1'b1}};
        end else begin
            etapa <= d;
            q     <= etapa;
        end
    end

endmodule

// File: rtl/escaner_teclado.sv
// 4x4 matrix keypad scanner with debounce on press and release.
// Define ESCANER_TECLADO_REPEAT_EN to enable auto-repeat pulses while a key is held.
module escaner_teclado
    import escaner_teclado_pkg::*;
#(
    parameter int SCAN_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [4:0] boton,
    output logic       tecla_valida
);

    localparam int WIN_W = $clog2(SCAN_CYCLES);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]       filas_sync;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] cuenta;
    logic [CNT_W-1:0] cuenta_sig;
    logic [1:0]       estado;
    logic [1:0]       fila_r;
    logic [1:0]       fila_sel;
    logic [1:0]       col_idx;
    logic [1:0]       col_sig;
    logic             muestra;
    logic             hay_fila;
    logic             misma_fila;
    logic             pulso_rep;

    sincronizador #(.WIDTH(4)) u_sinc (
        .clk (clk),
        .rst (rst),
        .d   (filas),
        .q   (filas_sync)
    );

    // Sample decode: lowest row index wins when several rows are low.
    always_comb begin
        muestra    = (win_cnt == WIN_LAST);
        hay_fila   = (filas_sync != 4'b1111);
        col_sig    = col_idx + 2'd1;
        cuenta_sig = cuenta + CNT_W'(1);
        if (!filas_sync[3]) begin
            fila_sel = 2'd0;
        end else if (!filas_sync[2]) begin
            fila_sel = 2'd1;
        end else if (!filas_sync[1]) begin
            fila_sel = 2'd2;
        end else begin
            fila_sel = 2'd3;
        end
        misma_fila = hay_fila && (fila_sel == fila_r);
    end

`ifdef ESCANER_TECLADO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_sig;

    // Repeat timing: a fresh period starts whenever HELD is (re)entered.
    always_comb begin
        rep_sig   = rep_cnt + REP_W'(1);
        pulso_rep = (estado == ST_HELD) && muestra && hay_fila && (rep_sig == REP_MAX);
    end

    // Samples-since-last-pulse counter, idle at zero outside HELD.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= {REP_W{1'b0}};
        end else if (estado != ST_HELD) begin
            rep_cnt <= {REP_W{1'b0}};
        end else if (muestra && hay_fila) begin
            rep_cnt <= (rep_sig == REP_MAX) ? {REP_W{1'b0}} : rep_sig;
        end else begin
            rep_cnt <= rep_cnt;
        end
    end
`else
    assign pulso_rep = 1'b0;
`endif

    // Window timer, scan/debounce FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt      <= {WIN_W{1'b0}};
            cuenta       <= {CNT_W{1'b0}};
            estado       <= ST_SCAN;
            fila_r       <= 2'd0;
            col_idx      <= 2'd0;
            columnas     <= 4'b0111;
            boton        <= 5'b00000;
            tecla_valida <= 1'b0;
        end else begin
            tecla_valida <= pulso_rep;
            win_cnt      <= muestra ? {WIN_W{1'b0}} : (win_cnt + WIN_W'(1));
            if (muestra) begin
                case (estado)
                    ST_SCAN: begin
                        if (hay_fila) begin
                            fila_r <= fila_sel;
                            cuenta <= CNT_W'(1);
                            estado <= ST_CONFIRM;
                        end else begin
                            col_idx  <= col_sig;
                            columnas <= columna_activa(col_sig);
                        end
                    end
                    ST_CONFIRM: begin
                        if (misma_fila && (cuenta_sig == CNT_MAX)) begin
                            boton        <= {1'b1, codigo_tecla(fila_r, col_idx)};
                            tecla_valida <= 1'b1;
                            cuenta       <= {CNT_W{1'b0}};
                            estado       <= ST_HELD;
                        end else if (misma_fila) begin
                            cuenta <= cuenta_sig;
                        end else begin
                            cuenta   <= {CNT_W{1'b0}};
                            estado   <= ST_SCAN;
                            col_idx  <= col_sig;
                            columnas <= columna_activa(col_sig);
                        end
                    end
                    ST_HELD: begin
                        if (!hay_fila) begin
                            cuenta <= CNT_W'(1);
                            estado <= ST_RELEASE;
                        end else begin
                            estado <= ST_HELD;
                        end
                    end
                    ST_RELEASE: begin
                        if (!hay_fila && (cuenta_sig == CNT_MAX)) begin
                            boton[4] <= 1'b0;
                            cuenta   <= {CNT_W{1'b0}};
                            estado   <= ST_SCAN;
                            col_idx  <= col_sig;
                            columnas <= columna_activa(col_sig);
                        end else if (!hay_fila) begin
                            cuenta <= cuenta_sig;
                        end else if (misma_fila) begin
                            cuenta <= {CNT_W{1'b0}};
                            estado <= ST_HELD;
                        end else begin
                            // Another row in this column: not a clean release yet.
                            cuenta <= {CNT_W{1'b0}};
                        end
                    end
                    default: begin
                        cuenta <= {CNT_W{1'b0}};
                        estado <= ST_SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_escaner_teclado.sv
// Self-checking bench: keypad matrix model driven by columnas, directed key scenarios.
module tb_escaner_teclado;

    localparam int SC = 4;
    localparam int DB = 3;
    localparam int RS = 5;
`ifdef ESCANER_TECLADO_REPEAT_EN
    localparam int EXTRA_EXP = 2;
    localparam int GAP_EXP   = 20;
`else
    localparam int EXTRA_EXP = 0;
    localparam int GAP_EXP   = -1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [4:0] boton;
    logic       tecla_valida;
    logic [15:0] pulsadas = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pulsadas[r*4+c] && !columnas[3-c]) filas[3-r] = 1'b0;
            end
        end
    end

    escaner_teclado #(
        .SCAN_CYCLES    (SC),
        .DEBOUNCE_SCANS (DB),
        .REPEAT_SCANS   (RS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filas        (filas),
        .columnas     (columnas),
        .boton        (boton),
        .tecla_valida (tecla_valida)
    );

    typedef struct {
        int         ciclo;
        logic [3:0] col;
        logic [4:0] bot;
        logic       val;
    } vec_t;

    vec_t tabla[9];

    task automatic comparar(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        n_cmp++;
        if (actual !== esperado) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nombre, actual, esperado);
        end
    endtask

    task automatic pulsar(input string nombre, input int r, input int c, input logic [4:0] esperado);
        bit visto;
        int extras;
        visto = 1'b0;
        pulsadas[r*4+c] = 1'b1;
        for (int i = 0; i < 120 && !visto; i++) begin
            @(negedge clk);
            if (tecla_valida) visto = 1'b1;
        end
        comparar({nombre, " pulse"}, 32'(visto), 32'd1);
        comparar({nombre, " boton"}, 32'(boton), 32'(esperado));
        extras = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tecla_valida) extras++;
        end
        comparar({nombre, " extra pulses"}, 32'(extras), 32'(EXTRA_EXP));
        comparar({nombre, " boton held"}, 32'(boton), 32'(esperado));
    endtask

    task automatic soltar(input string nombre, input logic [4:0] esperado);
        pulsadas = 16'h0000;
        repeat (8) @(negedge clk);
        comparar({nombre, " held flag before debounce"}, 32'(boton[4]), 32'd1);
        repeat (12) @(negedge clk);
        comparar({nombre, " boton released"}, 32'(boton), 32'(esperado));
    endtask

    task automatic medir_hueco(output int hueco);
        int t;
        t = -1;
        for (int i = 1; i <= 40 && t < 0; i++) begin
            @(negedge clk);
            if (tecla_valida) t = 0;
        end
        hueco = -1;
        if (t == 0) begin
            for (int i = 1; i <= 40 && hueco < 0; i++) begin
                @(negedge clk);
                if (tecla_valida) hueco = i;
            end
        end
    endtask

    initial begin
        int k;
        int pulsos;
        int hueco;
        bit hallado;
        logic [3:0] previa;

        tabla[0] = '{0,  4'b0111, 5'b00000, 1'b0};
        tabla[1] = '{1,  4'b0111, 5'b00000, 1'b0};
        tabla[2] = '{3,  4'b0111, 5'b00000, 1'b0};
        tabla[3] = '{4,  4'b1011, 5'b00000, 1'b0};
        tabla[4] = '{7,  4'b1011, 5'b00000, 1'b0};
        tabla[5] = '{8,  4'b1101, 5'b00000, 1'b0};
        tabla[6] = '{11, 4'b1101, 5'b00000, 1'b0};
        tabla[7] = '{12, 4'b1110, 5'b00000, 1'b0};
        tabla[8] = '{16, 4'b0111, 5'b00000, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        k = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 1) rst = 1'b0;
            repeat (tabla[i].ciclo - k) @(negedge clk);
            k = tabla[i].ciclo;
            comparar($sformatf("idle columnas c%0d", k), 32'(columnas), 32'(tabla[i].col));
            comparar($sformatf("idle boton c%0d", k), 32'(boton), 32'(tabla[i].bot));
            comparar($sformatf("idle valid c%0d", k), 32'(tecla_valida), 32'(tabla[i].val));
        end

        pulsar("key7", 2, 0, 5'b10111);
        soltar("key7", 5'b00111);
        pulsar("keyC", 2, 3, 5'b11100);
        soltar("keyC", 5'b01100);
        pulsar("keyHash", 3, 2, 5'b11111);
        soltar("keyHash", 5'b01111);

        // Glitch on key 8: present for exactly two samples of column 1.
        hallado = 1'b0;
        for (int i = 0; i < 40 && !hallado; i++) begin
            previa = columnas;
            @(negedge clk);
            if (previa != 4'b1011 && columnas == 4'b1011) hallado = 1'b1;
        end
        comparar("glitch found col1", 32'(hallado), 32'd1);
        pulsos = 0;
        pulsadas[2*4+1] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (tecla_valida) pulsos++;
        end
        pulsadas = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            if (tecla_valida) pulsos++;
        end
        comparar("glitch column frozen", 32'(columnas), 32'(4'b1011));
        @(negedge clk);
        comparar("glitch next column", 32'(columnas), 32'(4'b1101));
        repeat (12) begin
            @(negedge clk);
            if (tecla_valida) pulsos++;
        end
        comparar("glitch no pulse", 32'(pulsos), 32'd0);
        comparar("glitch boton kept", 32'(boton), 32'(5'b01111));

        pulsadas[0*4+0] = 1'b1;
        pulsar("keys1and4", 1, 0, 5'b10001);
        soltar("keys1and4", 5'b00001);

        pulsar("key5", 1, 1, 5'b10101);
        medir_hueco(hueco);
        comparar("key5 repeat gap", 32'(hueco), 32'(GAP_EXP));

        // Reset while the key is still held.
        rst = 1'b1;
        @(negedge clk);
        comparar("rst held boton", 32'(boton), 32'(5'b00000));
        comparar("rst held columnas", 32'(columnas), 32'(4'b0111));
        comparar("rst held valid", 32'(tecla_valida), 32'd0);
        pulsadas = 16'h0000;
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
